// File: rtl/uniform_f32_gen_if.sv
// Request/result bundle between the uniform sample source and its consumer.
// The master drives requests and seeds; the slave (the generator) returns samples.
interface uniform_f32_gen_if #(
  parameter int DSP_FP_SIZE = 32
);
  logic                   en;
  logic                   seed_wr;
  logic [95:0]            seed;
  logic                   rdy;
  logic [DSP_FP_SIZE-1:0] result;

  modport master (
    output en, seed_wr, seed,
    input  rdy, result
  );

  modport slave (
    input  en, seed_wr, seed,
    output rdy, result
  );
endinterface

// File: rtl/uniform_f32_gen.sv
// Taus88 uniform generator with a 3-stage int-to-float pipeline, samples in (0,1).
// Optional sample counter output is enabled by defining UNIFORM_SAMPLE_COUNT_EN.
module uniform_f32_gen #(
  parameter int          DELAY       = 1,
  parameter int          DSP_FP_SIZE = 32,
  parameter logic [31:0] SEED1       = 32'h1234_5678,
  parameter logic [31:0] SEED2       = 32'h9ABC_DEF0,
  parameter logic [31:0] SEED3       = 32'h0F1E_2D3C
) (
  input  logic                CLK,
  input  logic                RESET,
  uniform_f32_gen_if.slave    bus
`ifdef UNIFORM_SAMPLE_COUNT_EN
  ,
  output logic [31:0]         sample_count
`endif
);

  // DELAY exists for drop-in compatibility only; no timing is modelled here.
  if (DSP_FP_SIZE != 32 || DELAY < 0) begin : g_cfg_check
    $error("uniform_f32_gen: only DSP_FP_SIZE=32 and DELAY>=0 are supported");
  end

  function automatic logic [31:0] clamp_min(input logic [31:0] s, input logic [31:0] lo);
    return (s < lo) ? lo : s;
  endfunction

  function automatic logic [31:0] taus_s1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] taus_s2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] taus_s3(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  // The LSB of the fraction is forced to 1, so the count never exceeds 23.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] lz;
    lz = 5'd23;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lz = 5'(23 - i);
    end
    return lz;
  endfunction

  logic [31:0] s1_q, s1_d;
  logic [31:0] s2_q, s2_d;
  logic [31:0] s3_q, s3_d;
  logic [31:0] u;

  logic [23:0] v1_q, v1_d;
  logic        vld1_q, vld1_d;

  logic [23:0] v2_q, v2_d;
  logic [4:0]  lz2_q, lz2_d;
  logic        vld2_q, vld2_d;

  logic [23:0] norm;
  logic [31:0] result_q, result_d;
  logic        rdy_q, rdy_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    u        = 32'h0;
    v1_d     = v1_q;
    vld1_d   = 1'b0;
    v2_d     = v1_q;
    lz2_d    = lzc24(v1_q);
    vld2_d   = vld1_q;
    norm     = v2_q << lz2_q;
    result_d = result_q;
    rdy_d    = vld2_q;

    if (bus.seed_wr) begin
      s1_d   = clamp_min(bus.seed[31:0],  32'd2);
      s2_d   = clamp_min(bus.seed[63:32], 32'd8);
      s3_d   = clamp_min(bus.seed[95:64], 32'd16);
      // A reseed flushes everything in flight, including the sample about to retire.
      vld2_d = 1'b0;
      rdy_d  = 1'b0;
    end else if (bus.en) begin
      s1_d   = taus_s1(s1_q);
      s2_d   = taus_s2(s2_q);
      s3_d   = taus_s3(s3_q);
      u      = s1_d ^ s2_d ^ s3_d;
      v1_d   = {u[31:9], 1'b1};
      vld1_d = 1'b1;
    end

    if (vld2_q && !bus.seed_wr) begin
      result_d = {1'b0, 8'd126 - {3'b000, lz2_q}, norm[22:0]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q     <= clamp_min(SEED1, 32'd2);
      s2_q     <= clamp_min(SEED2, 32'd8);
      s3_q     <= clamp_min(SEED3, 32'd16);
      v1_q     <= '0;
      vld1_q   <= 1'b0;
      v2_q     <= '0;
      lz2_q    <= '0;
      vld2_q   <= 1'b0;
      result_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      v1_q     <= v1_d;
      vld1_q   <= vld1_d;
      v2_q     <= v2_d;
      lz2_q    <= lz2_d;
      vld2_q   <= vld2_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.rdy    = rdy_q;
  assign bus.result = result_q;

`ifdef UNIFORM_SAMPLE_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q + {31'd0, rdy_q};
    if (bus.seed_wr) count_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) count_q <= '0;
    else       count_q <= count_d;
  end

  assign sample_count = count_q;
`endif

endmodule
